// File: rtl/dvi_pkg.sv
// rtl/dvi_pkg.sv - shared state encoding and default 640x480@60 raster timing
package dvi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;

    localparam int RGB_W = 24;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

endpackage

// File: rtl/dvi_timing_counter.sv
// rtl/dvi_timing_counter.sv - h/v raster counters with end-of-frame flag and region decode
module dvi_timing_counter
    import dvi_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          clr_i,
    output logic [HW-1:0] h_o,
    output logic [VW-1:0] v_o,
    output logic          eof_o,
    output logic          active_o,
    output logic          hs_o,
    output logic          vs_o
);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          h_last, v_last;

    assign h_last = (int'(h_q) == H_TOTAL - 1);
    assign v_last = (int'(v_q) == V_TOTAL - 1);

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (clr_i) begin
            h_d = '0;
            v_d = '0;
        end else if (en_i) begin
            if (h_last) begin
                h_d = '0;
                v_d = v_last ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Line and frame order: active, front porch, sync, back porch
    assign h_o      = h_q;
    assign v_o      = v_q;
    assign eof_o    = h_last && v_last;
    assign active_o = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
    assign hs_o     = (int'(h_q) >= H_ACTIVE + H_FP) && (int'(h_q) < H_ACTIVE + H_FP + H_SYNC);
    assign vs_o     = (int'(v_q) >= V_ACTIVE + V_FP) && (int'(v_q) < V_ACTIVE + V_FP + V_SYNC);

endmodule

// File: rtl/dvi_link_sequencer.sv
// rtl/dvi_link_sequencer.sv - link start/stop FSM, pixel handshake and registered encoder-side outputs
module dvi_link_sequencer
    import dvi_pkg::*;
#(
    parameter int   H_ACTIVE       = DEF_H_ACTIVE,
    parameter int   H_FP           = DEF_H_FP,
    parameter int   H_SYNC         = DEF_H_SYNC,
    parameter int   H_BP           = DEF_H_BP,
    parameter int   V_ACTIVE       = DEF_V_ACTIVE,
    parameter int   V_FP           = DEF_V_FP,
    parameter int   V_SYNC         = DEF_V_SYNC,
    parameter int   V_BP           = DEF_V_BP,
    parameter logic HS_POL         = 1'b0,
    parameter logic VS_POL         = 1'b0,
    parameter int   STARTUP_FRAMES = 2
) (
    input  logic             i_pxlclk,
    input  logic             i_rstn,
    input  logic             i_enable,
    input  logic [RGB_W-1:0] i_pix_data,
    input  logic             i_pix_valid,
    output logic             o_pix_ready,
    output logic             o_sof,
    output logic [RGB_W-1:0] o_rgb,
    output logic             o_de,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic [1:0]       o_state,
    output logic             o_underrun,
    input  logic             i_clr_underrun
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int FW      = $clog2(STARTUP_FRAMES + 1);

    state_e           state_q;
    logic [FW-1:0]    frm_q;
    logic [HW-1:0]    h_pos;
    logic [VW-1:0]    v_pos;
    logic             eof, active, hs, vs;
    logic             running, streaming, go_idle, pix_ready, underrun_set;
    logic             de_q, hsync_q, vsync_q, underrun_q;
    logic [RGB_W-1:0] rgb_q;

    assign running   = (state_q != ST_IDLE);
    assign streaming = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign go_idle   = ((state_q == ST_WARMUP) && !i_enable) ||
                       ((state_q == ST_DRAIN) && !i_enable && eof);

    dvi_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk_i    (i_pxlclk),
        .rst_ni   (i_rstn),
        .en_i     (running),
        .clr_i    (go_idle),
        .h_o      (h_pos),
        .v_o      (v_pos),
        .eof_o    (eof),
        .active_o (active),
        .hs_o     (hs),
        .vs_o     (vs)
    );

    // Ready depends only on registered position/state so upstream sees no combinational loop
    assign pix_ready    = streaming && active;
    assign underrun_set = pix_ready && !i_pix_valid;

    always_ff @(posedge i_pxlclk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            frm_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    frm_q <= '0;
                    if (i_enable) state_q <= ST_WARMUP;
                end
                ST_WARMUP: begin
                    if (!i_enable) begin
                        state_q <= ST_IDLE;
                    end else if (eof) begin
                        if (int'(frm_q) == STARTUP_FRAMES - 1) state_q <= ST_RUN;
                        else                                   frm_q   <= frm_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!i_enable) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (i_enable)  state_q <= ST_RUN;
                    else if (eof)  state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_pxlclk or negedge i_rstn) begin
        if (!i_rstn) begin
            de_q       <= 1'b0;
            rgb_q      <= '0;
            hsync_q    <= ~HS_POL;
            vsync_q    <= ~VS_POL;
            underrun_q <= 1'b0;
        end else begin
            de_q    <= pix_ready;
            rgb_q   <= (pix_ready && i_pix_valid) ? i_pix_data : '0;
            hsync_q <= (running && hs) ? HS_POL : ~HS_POL;
            vsync_q <= (running && vs) ? VS_POL : ~VS_POL;
            if (underrun_set)        underrun_q <= 1'b1;
            else if (i_clr_underrun) underrun_q <= 1'b0;
        end
    end

    assign o_pix_ready = pix_ready;
    assign o_sof       = pix_ready && (h_pos == '0) && (v_pos == '0);
    assign o_rgb       = rgb_q;
    assign o_de        = de_q;
    assign o_hsync     = hsync_q;
    assign o_vsync     = vsync_q;
    assign o_state     = state_q;
    assign o_underrun  = underrun_q;

endmodule
